// File: rtl/rerouting_sequencer.sv
// Sequences STV broadcast/insert and VTS extract/reduce over one VRF read and one VRF write port.
// STV: 1 or LANES cycles; VTS: 2 or LANES+2 cycles; issue is stalled (req_ready low) while busy.
module rerouting_sequencer #(
  parameter int LANES  = 4,
  parameter int XLEN   = 32,
  parameter int LANE_W = 2,
  parameter int REG_W  = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              rerouting_select,
  input  logic [2:0]        rerouting_code,
  input  logic [LANE_W:0]   lane_idx,
  input  logic [XLEN-1:0]   scalar_data,
  input  logic [REG_W-1:0]  vreg_addr,
  input  logic [REG_W-1:0]  rd_addr,
  output logic [REG_W-1:0]  vrf_addr,
  output logic              vrf_wr_en,
  output logic [LANE_W-1:0] vrf_wr_lane,
  output logic [XLEN-1:0]   vrf_wr_data,
  output logic              vrf_rd_en,
  output logic [LANE_W-1:0] vrf_rd_lane,
  input  logic [XLEN-1:0]   vrf_rd_data,
  output logic              sc_wr_en,
  output logic [REG_W-1:0]  sc_wr_addr,
  output logic [XLEN-1:0]   sc_wr_data,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_STV_WR = 3'd1;
  localparam logic [2:0] S_VTS_RD = 3'd2;
  localparam logic [2:0] S_VTS_WB = 3'd3;
  localparam logic [2:0] S_ERR    = 3'd4;

  localparam int LW1 = LANE_W + 1;
  localparam logic [LANE_W:0] LANES_C = LW1'(LANES);
  localparam logic [LANE_W:0] LAST_C  = LW1'(LANES - 1);
  localparam logic [LANE_W:0] CNT_ONE = LW1'(1);

  logic [2:0]        state;
  logic [LANE_W:0]   cnt;
  logic [XLEN-1:0]   acc;
  logic              rd_pend;
  logic              single_q;
  logic [LANE_W-1:0] lane_q;
  logic [XLEN-1:0]   scalar_q;
  logic [REG_W-1:0]  vrf_addr_q;
  logic [REG_W-1:0]  sc_addr_q;

  logic       accept;
  logic       req_dir;
  logic [1:0] req_mode;
  logic       req_illegal;
  logic       last_wr;
  logic       rd_active;

  assign req_dir  = rerouting_code[2];
  assign req_mode = rerouting_code[1:0];

  // Out-of-range lanes are caught via the extra MSB of lane_idx.
  always_comb begin
    req_illegal = 1'b0;
    if (req_mode == 2'b00)
      req_illegal = 1'b1;
    else if (!req_dir && req_mode == 2'b11)
      req_illegal = 1'b1;
    else if (req_mode == 2'b10 && lane_idx >= LANES_C)
      req_illegal = 1'b1;
  end

  assign busy      = (state != S_IDLE);
  assign req_ready = !busy;
  assign accept    = req_valid && req_ready && rerouting_select;

  assign last_wr   = single_q || (cnt == LAST_C);
  // Reduce issues reads while cnt < LANES, then spends one cycle absorbing the last return.
  assign rd_active = (state == S_VTS_RD) && (single_q || cnt < LANES_C);

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      cnt        <= '0;
      acc        <= '0;
      rd_pend    <= 1'b0;
      single_q   <= 1'b0;
      lane_q     <= '0;
      scalar_q   <= '0;
      vrf_addr_q <= '0;
      sc_addr_q  <= '0;
    end else begin
      rd_pend <= rd_active;
      case (state)
        S_IDLE: begin
          if (accept) begin
            single_q   <= (req_mode == 2'b10);
            lane_q     <= lane_idx[LANE_W-1:0];
            scalar_q   <= scalar_data;
            vrf_addr_q <= vreg_addr;
            sc_addr_q  <= rd_addr;
            cnt        <= '0;
            acc        <= '0;
            if (req_illegal)
              state <= S_ERR;
            else if (req_dir)
              state <= S_VTS_RD;
            else
              state <= S_STV_WR;
          end
        end
        S_STV_WR: begin
          if (last_wr)
            state <= S_IDLE;
          else
            cnt <= cnt + CNT_ONE;
        end
        S_VTS_RD: begin
          if (rd_pend && !single_q)
            acc <= acc + vrf_rd_data;
          if (single_q || cnt == LANES_C)
            state <= S_VTS_WB;
          else
            cnt <= cnt + CNT_ONE;
        end
        S_VTS_WB: state <= S_IDLE;
        S_ERR:    state <= S_IDLE;
        default:  state <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    vrf_wr_en   = 1'b0;
    vrf_wr_lane = '0;
    vrf_wr_data = '0;
    vrf_rd_en   = 1'b0;
    vrf_rd_lane = '0;
    sc_wr_en    = 1'b0;
    sc_wr_data  = '0;
    done        = 1'b0;
    err         = 1'b0;
    case (state)
      S_STV_WR: begin
        vrf_wr_en   = 1'b1;
        vrf_wr_lane = single_q ? lane_q : cnt[LANE_W-1:0];
        vrf_wr_data = scalar_q;
        done        = last_wr;
      end
      S_VTS_RD: begin
        vrf_rd_en   = rd_active;
        vrf_rd_lane = rd_active ? (single_q ? lane_q : cnt[LANE_W-1:0]) : '0;
      end
      S_VTS_WB: begin
        sc_wr_en   = 1'b1;
        sc_wr_data = single_q ? vrf_rd_data : acc;
        done       = 1'b1;
      end
      S_ERR: err = 1'b1;
      default: ;
    endcase
  end

  assign vrf_addr   = vrf_addr_q;
  assign sc_wr_addr = sc_addr_q;

endmodule

// File: tb/tb_rerouting_sequencer.sv
// Cycle-by-cycle check of rerouting_sequencer outputs against a timing model built from the op rules.
module tb_rerouting_sequencer;
  localparam int LANES = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, rerouting_select;
  logic [2:0]  rerouting_code;
  logic [2:0]  lane_idx;
  logic [31:0] scalar_data;
  logic [4:0]  vreg_addr, rd_addr, vrf_addr, sc_wr_addr;
  logic        vrf_wr_en, vrf_rd_en, sc_wr_en, busy, done, err;
  logic [1:0]  vrf_wr_lane, vrf_rd_lane;
  logic [31:0] vrf_wr_data, vrf_rd_data, sc_wr_data;

  rerouting_sequencer #(.LANES(4), .XLEN(32), .LANE_W(2), .REG_W(5)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .rerouting_select(rerouting_select), .rerouting_code(rerouting_code),
    .lane_idx(lane_idx), .scalar_data(scalar_data), .vreg_addr(vreg_addr),
    .rd_addr(rd_addr), .vrf_addr(vrf_addr), .vrf_wr_en(vrf_wr_en),
    .vrf_wr_lane(vrf_wr_lane), .vrf_wr_data(vrf_wr_data), .vrf_rd_en(vrf_rd_en),
    .vrf_rd_lane(vrf_rd_lane), .vrf_rd_data(vrf_rd_data), .sc_wr_en(sc_wr_en),
    .sc_wr_addr(sc_wr_addr), .sc_wr_data(sc_wr_data), .busy(busy), .done(done),
    .err(err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic busy, ready, wr_en;
    logic [1:0]  wr_lane;
    logic [31:0] wr_data;
    logic        rd_en;
    logic [1:0]  rd_lane;
    logic        sc_en;
    logic [31:0] sc_data;
    logic        done, err;
  } obs_t;

  logic [31:0] mem [32][LANES];
  obs_t        exp_q[$];
  obs_t        obs;
  int          checks = 0;
  int          passed = 0;
  logic [4:0]  exp_vaddr = '0;
  logic [4:0]  exp_rdaddr = '0;
  logic        pend_en = 1'b0;
  logic [1:0]  pend_lane = '0;
  logic [4:0]  pend_addr = '0;

  function automatic obs_t idle_rec();
    obs_t r = '0;
    r.ready = 1'b1;
    return r;
  endfunction

  function automatic obs_t busy_rec();
    obs_t r = '0;
    r.busy = 1'b1;
    return r;
  endfunction

  task automatic check_obs(input string tag, input obs_t o, input obs_t e);
    checks++;
    assert (o === e) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, o, e);
  endtask

  task automatic check_val(input string tag, input logic [31:0] o, input logic [31:0] e);
    checks++;
    assert (o === e) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, o, e);
  endtask

  // Samples the current cycle at the falling edge, then plays the VRF: data for a read
  // issued in this cycle appears just after the next rising edge.
  task automatic tick();
    @(negedge clk);
    obs = {busy, req_ready, vrf_wr_en, vrf_wr_lane, vrf_wr_data, vrf_rd_en, vrf_rd_lane,
           sc_wr_en, sc_wr_data, done, err};
    pend_en   = vrf_rd_en;
    pend_lane = vrf_rd_lane;
    pend_addr = vrf_addr;
    @(posedge clk);
    #1;
    vrf_rd_data = pend_en ? mem[pend_addr][pend_lane] : $urandom();
  endtask

  // Expected trace for cycles T+1 onward, ending with one idle cycle.
  task automatic build_expected(input logic sel, input logic [2:0] code, input logic [2:0] lane,
                                input logic [31:0] scalar, input logic [4:0] vaddr);
    obs_t        r;
    logic [1:0]  mode;
    logic        dir;
    logic [31:0] sum;
    int          n;
    mode = code[1:0];
    dir  = code[2];
    exp_q.delete();
    if (!sel) begin
      exp_q.push_back(idle_rec());
    end else if (mode == 2'b00 || (!dir && mode == 2'b11) || (mode == 2'b10 && lane >= 3'(LANES))) begin
      r = busy_rec(); r.err = 1'b1; exp_q.push_back(r);
    end else if (!dir) begin
      n = (mode == 2'b10) ? 1 : LANES;
      for (int i = 0; i < n; i++) begin
        r = busy_rec(); r.wr_en = 1'b1;
        r.wr_lane = (mode == 2'b10) ? lane[1:0] : 2'(i);
        r.wr_data = scalar;
        r.done = (i == n - 1);
        exp_q.push_back(r);
      end
    end else if (mode == 2'b10) begin
      r = busy_rec(); r.rd_en = 1'b1; r.rd_lane = lane[1:0]; exp_q.push_back(r);
      r = busy_rec(); r.sc_en = 1'b1; r.sc_data = mem[vaddr][lane[1:0]]; r.done = 1'b1;
      exp_q.push_back(r);
    end else begin
      sum = '0;
      for (int i = 0; i < LANES; i++) begin
        sum += mem[vaddr][i];
        r = busy_rec(); r.rd_en = 1'b1; r.rd_lane = 2'(i); exp_q.push_back(r);
      end
      exp_q.push_back(busy_rec());
      r = busy_rec(); r.sc_en = 1'b1; r.sc_data = sum; r.done = 1'b1; exp_q.push_back(r);
    end
    exp_q.push_back(idle_rec());
  endtask

  task automatic run_op(input string name, input logic sel, input logic [2:0] code,
                        input logic [2:0] lane, input logic [31:0] scalar,
                        input logic [4:0] vaddr, input logic [4:0] rdaddr, input bit hold);
    build_expected(sel, code, lane, scalar, vaddr);
    req_valid = 1'b1; rerouting_select = sel; rerouting_code = code; lane_idx = lane;
    scalar_data = scalar; vreg_addr = vaddr; rd_addr = rdaddr;
    tick();
    check_obs({name, " T"}, obs, idle_rec());
    if (hold) begin
      scalar_data = ~scalar; vreg_addr = vaddr + 5'd1; rd_addr = rdaddr + 5'd1;
    end else begin
      req_valid = 1'b0;
    end
    foreach (exp_q[i]) begin
      if (i == exp_q.size() - 1) req_valid = 1'b0;
      tick();
      check_obs($sformatf("%s T+%0d", name, i + 1), obs, exp_q[i]);
    end
    if (sel) begin
      exp_vaddr  = vaddr;
      exp_rdaddr = rdaddr;
    end
    check_val({name, " vrf_addr"}, 32'(vrf_addr), 32'(exp_vaddr));
    check_val({name, " sc_wr_addr"}, 32'(sc_wr_addr), 32'(exp_rdaddr));
  endtask

  initial begin
    for (int a = 0; a < 32; a++)
      for (int l = 0; l < LANES; l++) mem[a][l] = $urandom();
    rst = 1'b1; req_valid = 1'b0; rerouting_select = 1'b0; rerouting_code = '0;
    lane_idx = '0; scalar_data = '0; vreg_addr = '0; rd_addr = '0; vrf_rd_data = '0;
    tick();
    tick();
    check_obs("reset outputs", obs, idle_rec());
    check_val("reset vrf_addr", 32'(vrf_addr), 32'd0);
    check_val("reset sc_wr_addr", 32'(sc_wr_addr), 32'd0);
    rst = 1'b0;
    tick();

    run_op("stv_all", 1'b1, 3'b001, 3'd0, 32'hDEADBEEF, 5'd5, 5'd0, 1'b0);
    mem[9][0] = 32'd1; mem[9][1] = 32'd2; mem[9][2] = 32'd3; mem[9][3] = 32'hFFFFFFFF;
    run_op("vts_reduce", 1'b1, 3'b111, 3'd0, 32'h0, 5'd9, 5'd7, 1'b0);
    mem[12][2] = 32'h00001234;
    run_op("vts_single", 1'b1, 3'b110, 3'd2, 32'h0, 5'd12, 5'd3, 1'b0);
    run_op("vts_mode01", 1'b1, 3'b101, 3'd0, 32'h0, 5'd9, 5'd4, 1'b0);
    run_op("illegal_011", 1'b1, 3'b011, 3'd0, 32'h1111, 5'd2, 5'd2, 1'b0);
    run_op("illegal_lane4", 1'b1, 3'b010, 3'd4, 32'h2222, 5'd6, 5'd8, 1'b0);
    run_op("illegal_mode00", 1'b1, 3'b100, 3'd1, 32'h3333, 5'd1, 5'd1, 1'b0);
    run_op("stv_single", 1'b1, 3'b010, 3'd3, 32'hCAFEF00D, 5'd14, 5'd0, 1'b0);
    run_op("not_selected", 1'b0, 3'b001, 3'd0, 32'h5555, 5'd30, 5'd31, 1'b0);
    run_op("stv_held_valid", 1'b1, 3'b001, 3'd0, 32'hA5A5A5A5, 5'd20, 5'd21, 1'b1);

    // Reset lands at the edge closing the second broadcast write.
    build_expected(1'b1, 3'b001, 3'd0, 32'h0BADF00D, 5'd11);
    req_valid = 1'b1; rerouting_select = 1'b1; rerouting_code = 3'b001;
    scalar_data = 32'h0BADF00D; vreg_addr = 5'd11; rd_addr = 5'd0;
    tick();
    req_valid = 1'b0;
    tick();
    check_obs("rst_mid T+1", obs, exp_q[0]);
    rst = 1'b1;
    tick();
    check_obs("rst_mid T+2", obs, exp_q[1]);
    rst = 1'b0;
    tick();
    check_obs("rst_mid T+3", obs, idle_rec());
    tick();
    check_obs("rst_mid T+4", obs, idle_rec());
    exp_vaddr = '0; exp_rdaddr = '0;

    for (int n = 0; n < 40; n++) begin
      logic [4:0] va;
      va = 5'($urandom_range(0, 31));
      for (int l = 0; l < LANES; l++) mem[va][l] = $urandom();
      run_op($sformatf("rand%0d", n), ($urandom_range(0, 7) != 0), 3'($urandom_range(0, 7)),
             3'($urandom_range(0, 5)), $urandom(), va, 5'($urandom_range(0, 31)),
             bit'($urandom_range(0, 1)));
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
